// File: rtl/afifo_pkg.sv
// ---------------------------------------------------------------------------
// afifo_pkg
//   Shared definitions for the asynchronous-FIFO write-side observer.
//   Holds the capture FSM encodings, both as plain 2-bit constants (used by
//   the RTL state register) and as an enum type for tools and benches that
//   prefer named states.
// ---------------------------------------------------------------------------
package afifo_pkg;

    // Capture FSM encodings. These are visible on the `state` output, so the
    // numeric values are part of the interface and must not be reordered.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        OBS_IDLE  = ST_IDLE,
        OBS_ARMED = ST_ARMED,
        OBS_POST  = ST_POST,
        OBS_DONE  = ST_DONE
    } afifo_obs_state_e;

endpackage

// File: rtl/afifo_obs_trace_ram.sv
// ---------------------------------------------------------------------------
// afifo_obs_trace_ram
//   Simple dual-port trace memory: DEPTH x DATA_WIDTH, one synchronous write
//   port and one read port with a registered output (one cycle latency).
//   Contents are deliberately not reset so the array maps onto block RAM.
//
//   Ports
//     clk    in   clock for both ports
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     re     in   read enable; rdata updates on the next edge only when set
//     raddr  in   read address
//     rdata  out  registered read data
// ---------------------------------------------------------------------------
module afifo_obs_trace_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register is only loaded on a request so the last word stays
    // stable while no readout is in flight.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/afifo_wr_observer.sv
// ---------------------------------------------------------------------------
// afifo_wr_observer
//   Passive monitor on the write side of an asynchronous FIFO. It counts
//   accepted and overflowing writes, and runs a trigger-based trace capture:
//   after `arm`, every accepted word is written into a circular trace buffer
//   until a masked compare hits; a programmable number of post-trigger words
//   is then recorded and the trace is read back oldest-first via rd_req.
//
//   Ports
//     wclk        in   write-domain clock
//     wrst_n      in   asynchronous active-low reset
//     winc        in   FIFO write request
//     wfull       in   FIFO full flag
//     wdata       in   FIFO write data
//     arm         in   single-cycle capture start/restart pulse
//     trig_mask   in   bits of wdata that take part in the trigger compare
//     trig_value  in   trigger compare value
//     post_trig   in   words to record after the trigger word
//     rd_req      in   trace readout request (honoured only in DONE)
//     rd_valid    out  rd_data valid
//     rd_data     out  trace word
//     rd_last     out  last trace word of this capture
//     wr_count    out  saturating count of accepted writes
//     ovf_count   out  saturating count of writes attempted while full
//     ovf_sticky  out  an overflow occurred since reset or the last arm
//     state       out  capture FSM state (IDLE/ARMED/POST/DONE)
//     trig_hit    out  trigger seen in the current capture
// ---------------------------------------------------------------------------
module afifo_wr_observer
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                           wclk,
    input  logic                           wrst_n,
    input  logic                           winc,
    input  logic                           wfull,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           arm,
    input  logic [DATA_WIDTH-1:0]          trig_mask,
    input  logic [DATA_WIDTH-1:0]          trig_value,
    input  logic [$clog2(TRACE_DEPTH):0]   post_trig,
    input  logic                           rd_req,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_last,
    output logic [CNT_WIDTH-1:0]           wr_count,
    output logic [CNT_WIDTH-1:0]           ovf_count,
    output logic                           ovf_sticky,
    output logic [1:0]                     state,
    output logic                           trig_hit
);

    localparam int PW  = $clog2(TRACE_DEPTH);   // trace pointer width
    localparam int FW  = PW + 1;                // fill count, 0..TRACE_DEPTH
    localparam int PTW = PW + 1;                // post-trigger count width

    // Elaboration guard: the ring arithmetic relies on a power-of-two depth.
    // ADDR_WIDTH is only carried for bus compatibility and is sanity-checked.
    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0 || ADDR_WIDTH < 1)
    begin : g_bad_params
        $error("afifo_wr_observer: TRACE_DEPTH must be a power of two >= 2");
    end

    // ------------------------------------------------------------------
    // Write-port classification
    // ------------------------------------------------------------------
    logic accept;
    logic ovf;

    assign accept = winc & ~wfull;
    assign ovf    = winc &  wfull;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] wr_count_q,  wr_count_d;
    logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;
    logic                 ovf_sticky_q, ovf_sticky_d;

    always_comb begin
        wr_count_d   = wr_count_q;
        ovf_count_d  = ovf_count_q;
        ovf_sticky_d = ovf_sticky_q;

        if (accept && (wr_count_q != {CNT_WIDTH{1'b1}})) begin
            wr_count_d = wr_count_q + CNT_WIDTH'(1);
        end
        if (ovf && (ovf_count_q != {CNT_WIDTH{1'b1}})) begin
            ovf_count_d = ovf_count_q + CNT_WIDTH'(1);
        end

        // A coincident overflow wins over the clear from arm so that an
        // overflow in the arm cycle is never lost.
        if (ovf) begin
            ovf_sticky_d = 1'b1;
        end else if (arm) begin
            ovf_sticky_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM and trace bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]     state_q,     state_d;
    logic [PW-1:0]  wptr_q,      wptr_d;
    logic [FW-1:0]  fill_q,      fill_d;
    logic [PTW-1:0] remain_q,    remain_d;
    logic           trig_hit_q,  trig_hit_d;
    logic [FW-1:0]  rd_issued_q, rd_issued_d;
    logic           rd_valid_q,  rd_valid_d;
    logic           rd_last_q,   rd_last_d;

    logic                  trig_match;
    logic [PTW-1:0]        post_clamped;
    logic                  record;
    logic                  ram_we;
    logic                  ram_re;
    logic [PW-1:0]         rd_base;
    logic [PW-1:0]         ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign trig_match   = ((wdata ^ trig_value) & trig_mask) == '0;
    assign post_clamped = (post_trig > PTW'(TRACE_DEPTH - 1)) ? PTW'(TRACE_DEPTH - 1)
                                                               : post_trig;

    // Oldest entry sits `fill` slots behind the write pointer. When the ring
    // is full, fill[PW-1:0] is zero and the oldest entry is wptr itself.
    assign rd_base   = wptr_q - fill_q[PW-1:0];
    assign ram_raddr = rd_base + rd_issued_q[PW-1:0];

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        remain_d    = remain_q;
        trig_hit_d  = trig_hit_q;
        rd_issued_d = rd_issued_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        record      = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        case (state_q)
            ST_ARMED: begin
                if (accept) begin
                    record = 1'b1;
                    if (trig_match) begin
                        trig_hit_d = 1'b1;
                        remain_d   = post_clamped;
                        state_d    = (post_clamped == '0) ? ST_DONE : ST_POST;
                    end
                end
            end

            ST_POST: begin
                // remain_q is at least 1 here: a zero count goes straight
                // from ARMED to DONE.
                if (accept) begin
                    record   = 1'b1;
                    remain_d = remain_q - PTW'(1);
                    if (remain_q == PTW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // rd_last is on the outputs this cycle: readout is complete.
                if (rd_last_q) begin
                    state_d = ST_IDLE;
                end else if (rd_req && (rd_issued_q != fill_q)) begin
                    ram_re      = 1'b1;
                    rd_issued_d = rd_issued_q + FW'(1);
                    rd_valid_d  = 1'b1;
                    rd_last_d   = (rd_issued_q + FW'(1)) == fill_q;
                end
            end

            default: begin
            end
        endcase

        if (record) begin
            ram_we = 1'b1;
            wptr_d = wptr_q + PW'(1);
            if (fill_q != FW'(TRACE_DEPTH)) begin
                fill_d = fill_q + FW'(1);
            end
        end

        // arm restarts the capture from any state and swallows whatever
        // else happened in its cycle, including an accept or a read.
        if (arm) begin
            state_d     = ST_ARMED;
            wptr_d      = '0;
            fill_d      = '0;
            remain_d    = '0;
            trig_hit_d  = 1'b0;
            rd_issued_d = '0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            ram_we      = 1'b0;
            ram_re      = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_count_q   <= '0;
            ovf_count_q  <= '0;
            ovf_sticky_q <= 1'b0;
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            fill_q       <= '0;
            remain_q     <= '0;
            trig_hit_q   <= 1'b0;
            rd_issued_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            wr_count_q   <= wr_count_d;
            ovf_count_q  <= ovf_count_d;
            ovf_sticky_q <= ovf_sticky_d;
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            remain_q     <= remain_d;
            trig_hit_q   <= trig_hit_d;
            rd_issued_q  <= rd_issued_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Trace storage
    // ------------------------------------------------------------------
    afifo_obs_trace_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TRACE_DEPTH),
        .AW         (PW)
    ) u_trace_ram (
        .clk   (wclk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The RAM read register has no reset, so the data is qualified by the
    // (reset) valid flop to keep rd_data at zero in reset and when idle.
    assign rd_data    = rd_valid_q ? ram_rdata : '0;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign wr_count   = wr_count_q;
    assign ovf_count  = ovf_count_q;
    assign ovf_sticky = ovf_sticky_q;
    assign state      = state_q;
    assign trig_hit   = trig_hit_q;

endmodule

// File: doc/afifo_wr_observer.md
AFIFO_WR_OBSERVER -- requirements
Module: afifo_wr_observer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, write-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, FIFO address width, carried for bus compatibility only.
REQ-003 SHALL have parameter TRACE_DEPTH, default 16, trace entries; power of two, >=2.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, statistics counter width.
REQ-005 SHALL have ports:
- wclk  in  1  write-domain clock; one clock only.
- wrst_n  in  1  reset, asynchronous, active-low.
- winc  in  1  FIFO write request.
- wfull  in  1  FIFO full flag.
- wdata  in  DATA_WIDTH  FIFO write data.
- arm  in  1  single-cycle capture start/restart pulse.
- trig_mask  in  DATA_WIDTH  trigger compare mask.
- trig_value  in  DATA_WIDTH  trigger compare value.
- post_trig  in  $clog2(TRACE_DEPTH)+1  words to record after the trigger word.
- rd_req  in  1  trace readout request.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  trace word.
- rd_last  out  1  last trace word.
- wr_count  out  CNT_WIDTH  accepted writes.
- ovf_count  out  CNT_WIDTH  writes attempted while full.
- ovf_sticky  out  1  overflow seen since reset/arm.
- state  out  2  FSM state.
- trig_hit  out  1  trigger occurred in current capture.

Function
REQ-006 SHALL define accept = winc & ~wfull and ovf = winc & wfull, both sampled at posedge wclk.
REQ-007 SHALL increment wr_count on accept and ovf_count on ovf; each saturates at all-ones; neither is affected by arm.
REQ-008 SHALL set ovf_sticky on any ovf and clear it on arm; ovf and arm in the same cycle leave it set.
REQ-009 SHALL implement the FSM IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-010 SHALL, on arm in any state, clear write pointer, fill count and trig_hit, discard any accept in that cycle, and enter ARMED next cycle; arm has priority over all other transitions.
REQ-011 SHALL, in ARMED, write each accepted wdata into the trace ring at the write pointer, wrapping modulo TRACE_DEPTH; fill count saturates at TRACE_DEPTH.
REQ-012 SHALL trigger on an ARMED accept where ((wdata ^ trig_value) & trig_mask) == 0; the trigger word is recorded, trig_hit set, and post_trig latched with values >TRACE_DEPTH-1 clamped to TRACE_DEPTH-1.
REQ-013 SHALL go from ARMED to DONE when the latched post_trig is 0, otherwise to POST.
REQ-014 SHALL, in POST, record each accept and decrement the remaining count, entering DONE on the accept that reaches 0.
REQ-015 SHALL, in DONE, ignore accepts for the trace and service rd_req; rd_req outside DONE SHALL be ignored.
REQ-016 SHALL drive rd_valid and rd_data exactly one cycle after an accepted rd_req, oldest entry first, at (wptr - fill) mod TRACE_DEPTH.
REQ-017 SHALL assert rd_last with the fill-th word, then enter IDLE the following cycle.
REQ-018 SHALL hold rd_valid low in every cycle without a serviced request.
REQ-019 SHALL, with an all-zero trig_mask, trigger on the first ARMED accept.

Reset
REQ-020 SHALL, while wrst_n is low, force state IDLE and all outputs to 0, including the counters, ovf_sticky, trig_hit, rd_valid, rd_data and rd_last.
REQ-021 SHALL reset the internal pointers and counts to 0; trace storage contents are not reset.
REQ-022 SHALL drop any capture or readout in progress when reset is asserted; after release it SHALL require arm.

Structure
REQ-023 SHALL place the afifo_obs_state_e enum and the state encodings in afifo_pkg.
REQ-024 SHALL instantiate the trace storage as sub-module afifo_obs_trace_ram: TRACE_DEPTH x DATA_WIDTH, one write port and one registered read port.

Verification
REQ-025 SHALL cover: 5 accepts, then 3 winc with wfull=1 -> wr_count=5, ovf_count=3, ovf_sticky=1.
REQ-026 SHALL cover: arm; writes 0x10..0x13; trig_mask=0xFF, trig_value=0x12, post_trig=1 -> DONE after 0x13; readout 0x10,0x11,0x12,0x13, with rd_last on 0x13.
REQ-027 SHALL cover: TRACE_DEPTH=16; arm; 20 writes 1..20 with the trigger on 20 and post_trig=0 -> readout 5..20 (16 words, wrap).
REQ-028 SHALL cover: post_trig=31 with TRACE_DEPTH=16 -> exactly 15 post-trigger words recorded before DONE.
REQ-029 SHALL cover: arm coincident with an accept of 0xAA in ARMED -> 0xAA not recorded, fill=0, state ARMED.
REQ-030 SHALL cover: wrst_n asserted mid-POST -> state=0 and all outputs 0 immediately; rd_req after release yields no rd_valid.
